// File: rtl/clic_irq_sender.sv
// CLIC interrupt transmitter: pending latch, per-source config, max-level arbitration, offer/kill handshake.
// Edge-triggered sources exist only when CLIC_EDGE_TRIG_EN is defined.
module clic_irq_sender #(
    parameter int unsigned NumSrc = 256,
    parameter int unsigned SrcW   = $clog2(NumSrc)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumSrc-1:0] irq_src_i,
    input  logic              cfg_we_i,
    input  logic [SrcW-1:0]   cfg_addr_i,
    input  logic [15:0]       cfg_wdata_i,
    output logic [15:0]       cfg_rdata_o,
    input  logic [7:0]        thresh_i,
    output logic              irq_valid_o,
    input  logic              irq_ready_i,
    output logic [SrcW-1:0]   irq_id_o,
    output logic [7:0]        irq_level_o,
    output logic              irq_shv_o,
    output logic              kill_req_o,
    input  logic              kill_ack_i
);

    typedef enum logic [1:0] {IDLE, OFFER, KILL} state_t;

    state_t            state, state_next;
    logic [NumSrc-1:0] ie, shv, ip, edge_trig, elig;
    logic [7:0]        level [NumSrc];
    logic              arb_valid, arb_shv;
    logic [SrcW-1:0]   arb_id;
    logic [7:0]        arb_level;
    logic              best_valid, best_shv;
    logic [SrcW-1:0]   best_id;
    logic [7:0]        best_level;
    logic [SrcW-1:0]   off_id;
    logic [7:0]        off_level;
    logic              off_shv;
    logic              accept, load, off_elig;
    logic              unused_wdata;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ie  <= '0;
            shv <= '0;
            for (int unsigned i = 0; i < NumSrc; i++) level[i] <= '0;
        end else if (cfg_we_i) begin
            ie[cfg_addr_i]    <= cfg_wdata_i[0];
            shv[cfg_addr_i]   <= cfg_wdata_i[2];
            level[cfg_addr_i] <= cfg_wdata_i[15:8];
        end
    end

`ifdef CLIC_EDGE_TRIG_EN
    logic [NumSrc-1:0] prev_src;

    assign unused_wdata = ^cfg_wdata_i[7:4];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            edge_trig <= '0;
            prev_src  <= '0;
        end else begin
            prev_src <= irq_src_i;
            if (cfg_we_i) edge_trig[cfg_addr_i] <= cfg_wdata_i[1];
        end
    end

    // Edge ip priority: new rising edge, then config write, then accept-clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ip <= '0;
        end else begin
            for (int unsigned i = 0; i < NumSrc; i++) begin
                if (!edge_trig[i])
                    ip[i] <= irq_src_i[i];
                else if (irq_src_i[i] && !prev_src[i])
                    ip[i] <= 1'b1;
                else if (cfg_we_i && cfg_addr_i == SrcW'(i))
                    ip[i] <= cfg_wdata_i[3];
                else if (accept && off_id == SrcW'(i))
                    ip[i] <= 1'b0;
            end
        end
    end
`else
    assign edge_trig    = '0;
    assign unused_wdata = ^{cfg_wdata_i[7:4], cfg_wdata_i[3], cfg_wdata_i[1]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ip <= '0;
        else       ip <= irq_src_i;
    end
`endif

    always_comb begin
        for (int unsigned i = 0; i < NumSrc; i++)
            elig[i] = ip[i] & ie[i] & (level[i] > thresh_i);
    end

    // Strict compare while scanning upward keeps the lowest id on level ties.
    always_comb begin
        arb_valid = 1'b0;
        arb_id    = '0;
        arb_level = '0;
        arb_shv   = 1'b0;
        for (int unsigned i = 0; i < NumSrc; i++) begin
            if (elig[i] && (!arb_valid || level[i] > arb_level)) begin
                arb_valid = 1'b1;
                arb_id    = SrcW'(i);
                arb_level = level[i];
                arb_shv   = shv[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            best_valid <= 1'b0;
            best_id    <= '0;
            best_level <= '0;
            best_shv   <= 1'b0;
        end else begin
            best_valid <= arb_valid;
            best_id    <= arb_id;
            best_level <= arb_level;
            best_shv   <= arb_shv;
        end
    end

    assign off_elig = elig[off_id];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        irq_valid_o = 1'b0;
        kill_req_o  = 1'b0;
        accept      = 1'b0;
        load        = 1'b0;
        case (state)
            IDLE: begin
                if (best_valid) begin
                    load       = 1'b1;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                irq_valid_o = 1'b1;
                if (irq_ready_i) begin
                    accept     = 1'b1;
                    state_next = IDLE;
                end else if ((best_valid && best_level > off_level) || !off_elig) begin
                    state_next = KILL;
                end
            end
            KILL: begin
                kill_req_o = 1'b1;
                if (kill_ack_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            off_id    <= '0;
            off_level <= '0;
            off_shv   <= 1'b0;
        end else if (load) begin
            off_id    <= best_id;
            off_level <= best_level;
            off_shv   <= best_shv;
        end
    end

    assign irq_id_o    = off_id;
    assign irq_level_o = off_level;
    assign irq_shv_o   = off_shv;

    always_comb begin
        cfg_rdata_o = {level[cfg_addr_i], 4'b0000, ip[cfg_addr_i], shv[cfg_addr_i],
                       edge_trig[cfg_addr_i], ie[cfg_addr_i]};
    end

endmodule

// File: doc/clic_irq_sender.md
Name: clic_irq_sender

Overview:
- Target-side interrupt source for the core's CLIC port: pending latch, per-source config, max-level arbitration, valid/ready offer with kill/ack retraction.
- The core's CLIC interface is the receiver; this block is the transmitter feeding it.
- Sits between platform interrupt lines and the core, enabled when the CLIC extension is configured.

Parameters:
- NumSrc, 256, number of interrupt sources (matches CLIC source count).
- SrcW, $clog2(NumSrc), width of source id.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- irq_src_i  in  NumSrc  raw interrupt lines, synchronous to clk_i
- cfg_we_i  in  1  config write strobe
- cfg_addr_i  in  SrcW  source index for config read/write
- cfg_wdata_i  in  16  [0] ie, [1] edge, [2] shv, [3] ip (write), [15:8] level
- cfg_rdata_o  out  16  same layout, bit3 = current ip; combinational read of cfg_addr_i
- thresh_i  in  8  interrupt level threshold
- irq_valid_o  out  1  interrupt offered to core
- irq_ready_i  in  1  core accepts offered interrupt
- irq_id_o  out  SrcW  offered source id
- irq_level_o  out  8  offered level
- irq_shv_o  out  1  selective hardware vectoring for offered source
- kill_req_o  out  1  request core to drop the outstanding offer
- kill_ack_i  in  1  core acknowledges kill

Behaviour:
- Reset: all config and ip bits 0, prev-source register 0, best_valid 0, FSM IDLE; all outputs 0.
- Pending, level source (edge=0): ip <= irq_src_i every cycle.
- Pending, edge source (edge=1): ip set on 0->1 of irq_src_i against the registered previous value.
- Edge-source ip clear: on accept (valid&ready) of that id, or by a config write of bit3.
  - Set and accept-clear in the same cycle: set wins.
  - Config write and accept-clear on the same source in the same cycle: config write wins.
- Config write: updates ie/edge/shv/level of cfg_addr_i at the clock edge. The bit3 write is ignored for level sources.
- Eligibility: ip & ie & (level > thresh_i). Level 0 is never eligible.
- Arbitration (combinational over all sources): highest level wins; ties go to the lowest id. The result is registered into best_valid/best_id/best_level/best_shv each cycle.
- Latency, idle block: source high before rising edge k gives ip after k, best after k+1, irq_valid_o after k+2.
- FSM IDLE: irq_valid_o=0. If best_valid, capture best_* into the output registers and go to OFFER.
- FSM OFFER: irq_valid_o=1, id/level/shv held stable.
  - irq_ready_i: accept, go to IDLE (valid low the next cycle). Ready takes priority over any kill condition in the same cycle.
  - Otherwise, if best_valid with best_level > offered level (preemption), or the offered source is no longer eligible: go to KILL.
  - Eligibility is re-evaluated against the live ip/ie/level/thresh_i.
- FSM KILL: irq_valid_o=0, kill_req_o=1.
  - On kill_ack_i: go to IDLE, kill_req_o low the next cycle.
  - irq_ready_i is ignored in KILL.
- Back-to-back: after accept or kill, a new offer follows at the earliest two cycles later (IDLE, then OFFER).
- thresh_i changes take effect on the next arbitration cycle. Raising thresh_i to or above the offered level triggers KILL.

Optional Feature:
- CLIC_EDGE_TRIG_EN defined: edge-triggered sources supported as above.
- Undefined: edge bit forced 0 (reads 0, writes ignored), all sources level-triggered, the bit3 ip write is ignored, and no prev-source register is instantiated.

Test Plan:
- Config src 5 (ie=1, level=0x40), thresh=0, pulse irq_src_i[5] high -> irq_valid_o on the 3rd edge, id=5, level=0x40. Ready same cycle -> valid low next cycle.
- Srcs 3 and 7 both at level 0x80, pending the same cycle -> id=3 offered. After accept with src 3 still high (level) -> id=3 re-offered two cycles later.
- Offer id=5 level 0x40 outstanding; raise src 9 at level 0xC0 -> KILL, kill_req_o=1, valid=0. kill_ack_i -> IDLE, then offer id=9 level 0xC0.
- Offer id=5 level 0x40; set thresh_i=0x40 -> KILL. After ack no offer while thresh_i=0x40.
- CLIC_EDGE_TRIG_EN: src 12 edge=1, level 0x10, single-cycle pulse -> ip stays 1 and offer id=12. Accept -> cfg_rdata_o[3]=0 for addr 12. New pulse in the accept cycle -> ip stays 1.
- Assert rst_i in OFFER -> valid/kill/id/level outputs immediately 0; after release no offer until new pending (config cleared).
